unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It arbitrates per transaction and latches the winning request. It drives the memory port until the memory answers with `mem_ready`, then returns read data with a one-cycle valid pulse. It also produces the stall signals the hazard logic uses to freeze PC/IF-ID and the later pipeline registers.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 15, cycles in a busy state without `mem_ready` before the transaction is aborted
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `if_req` in 1: fetch request, held until `if_valid`
- `if_addr` in ADDR_W: fetch address (PC)
- `if_rdata` out DATA_W: fetched instruction, registered
- `if_valid` out 1: one-cycle completion pulse for a fetch
- `if_stall` out 1: `if_req & ~if_valid`
- `d_read` / `d_write` in 1: load / store request from MEM, held until `d_valid`; never both high
- `d_addr` in ADDR_W; `d_wdata` in DATA_W: data address and store data
- `d_rdata` out DATA_W: load data, registered, unchanged by stores
- `d_valid` out 1: one-cycle completion pulse for a load or store
- `d_stall` out 1: `(d_read | d_write) & ~d_valid`
- `mem_en` out 1: memory access active
- `mem_we` out 1: write strobe
- `mem_addr` out ADDR_W; `mem_wdata` out DATA_W: registered request to memory
- `mem_rdata` in DATA_W: memory read data, sampled when `mem_ready` is high
- `mem_ready` in 1: memory completes the current access this cycle
- `timeout` out 1: sticky error, set on any aborted transaction

## Operation
- FSM states are IDLE, IF_BUSY and D_BUSY. Arbitration is combinational in IDLE only.
- **IDLE, data pending:** D_BUSY wins, unless the starvation rule applies.
- **IDLE, only `if_req` pending:** IF_BUSY.
- **Starvation rule:**
  - A 2-bit `starve` count increments each arbitration where `if_req` loses to data.
  - At `starve == 2`, IF wins the next tie; `starve` then clears.
  - `starve` also clears on any IF grant.
- **On grant:** `mem_addr`, `mem_wdata` and `mem_we` (= `d_write`; 0 for fetch) are latched, and `mem_en` rises. All of these are held constant while busy.
- **Busy with `mem_ready` high:**
  - Capture `mem_rdata` into `if_rdata` or `d_rdata` (loads and fetches only).
  - Pulse the matching valid on the next cycle.
  - Return to IDLE; `mem_en` drops.
- **Completion mask:** in the cycle a valid pulse is high, the completed requester's request is ignored by arbitration. This prevents re-granting a request the pipeline is about to retire.
- **Withdrawn request:** if a request drops mid-transaction, the transaction still completes and the valid pulse still fires.
- **Timeout:**
  - A wait counter counts busy cycles.
  - On reaching `MAX_WAIT` without `mem_ready`, the arbiter aborts, pulses the matching valid with rdata = 0, sets `timeout` and returns to IDLE.
  - `timeout` clears only on `rst`.
- **Reset:**
  - `rst` (also mid-transaction) forces IDLE, clears `starve`, the wait counter, `timeout`, both rdata registers and all valids, and drops `mem_en` and `mem_we` to 0.
  - The in-flight access is dropped with no valid pulse.

## Timing
- Reset values are 0 for all outputs.
- **Min latency:** request in IDLE at cycle 0 → `mem_en` high in cycle 1 → `mem_ready` in cycle 1 → valid plus data in cycle 2.
- **General latency:** with `mem_ready` in cycle k, valid is in cycle k+1.
- Throughput is one transaction per 2 cycles with a zero-wait memory. A new grant may occur in the valid cycle for the *other* requester.
- A `mem_ready` arriving while IDLE is ignored.

## Structure
- The shared package `mem_arb_pkg` holds the state enum (IDLE/IF_BUSY/D_BUSY), a grant-owner enum (GNT_IF/GNT_D), and the starvation threshold constant (2).
- The block is a single module. The only natural sub-module is `arb_wait_counter`: load/clear, increment, terminal-count flag at `MAX_WAIT`.

## Test plan
1. **Single fetch:** `if_req=1`, `if_addr=0x40`, zero-wait memory returning 0x8C020004 → `mem_en` in cycle 1, `if_valid` and `if_rdata=0x8C020004` in cycle 2, no `d_valid`.
2. **Simultaneous requests:** `if_req` and `d_read`@0x10 in the same cycle → data granted first; `d_valid` in cycle 2, fetch granted in cycle 2, `if_valid` in cycle 4.
3. **Starvation:** `if_req` held high while `d_read` re-asserts every cycle → IF wins on the third tie; `if_valid` occurs in bounded time, ≤ 6 cycles.
4. **Store plus wait states:** `d_write`@0x08, `d_wdata=0xDEADBEEF`, `mem_ready` after 3 cycles → `mem_we` held high for 3 cycles, `d_valid` one cycle later, `d_rdata` unchanged.
5. **Timeout:** `d_read` with `mem_ready` stuck at 0 → after 15 busy cycles `d_valid=1`, `d_rdata=0`, `timeout=1` and stays 1; a later fetch still completes normally.
6. **Reset mid-access:** `rst` pulsed in the second busy cycle → next cycle IDLE, `mem_en=0`, all outputs 0, no valid pulse; the held request is re-granted after reset deasserts.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified IF/MEM memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIfBusy,
    StDBusy
  } arb_state_e;

  typedef enum logic {
    GntIf,
    GntD
  } gnt_owner_e;

  // Number of lost ties after which the fetch side wins the next tie.
  localparam int unsigned StarveThresh = 2;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline request/response and memory-port signals of the unified memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              timeout;

  // The arbiter serves the pipeline stages and the memory.
  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata, timeout
  );

  // Environment view: pipeline requesters plus the memory model.
  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata, timeout
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Busy-cycle counter; tc is high during the MAX_WAIT-th busy cycle of a transaction.
module arb_wait_counter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !tc) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count is 0 in the first busy cycle, so MAX_WAIT-1 marks the MAX_WAIT-th one.
  assign tc = (cnt_q == CntW'(MAX_WAIT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// with starvation protection for fetch and a per-transaction timeout.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  gnt_owner_e        gnt;
  logic              gnt_en;
  logic [1:0]        starve_q, starve_d;
  logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rdata_sel;
  logic              mem_we_q, mem_we_d, timeout_q, timeout_d;
  logic              if_pend, d_pend, wait_clr, wait_inc, wait_tc;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (wait_clr),
    .inc (wait_inc),
    .tc  (wait_tc)
  );

  // A requester whose valid pulse is high is about to retire; do not re-grant it.
  assign if_pend = bus.if_req & ~if_valid_q;
  assign d_pend  = (bus.d_read | bus.d_write) & ~d_valid_q;

  always_comb begin
    gnt    = GntD;
    gnt_en = if_pend | d_pend;
    if (if_pend && (!d_pend || starve_q == 2'(StarveThresh))) begin
      gnt = GntIf;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    timeout_d   = timeout_q;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    rdata_sel   = bus.mem_ready ? bus.mem_rdata : '0;
    unique case (state_q)
      StIdle: begin
        wait_clr = 1'b1;
        if (gnt_en) begin
          if (gnt == GntIf) begin
            state_d    = StIfBusy;
            starve_d   = '0;
            mem_addr_d = bus.if_addr;
            mem_we_d   = 1'b0;
          end else begin
            state_d     = StDBusy;
            starve_d    = if_pend ? starve_q + 2'd1 : starve_q;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_we_d    = bus.d_write;
          end
        end
      end
      StIfBusy, StDBusy: begin
        wait_inc = 1'b1;
        // A ready arriving in the terminal cycle still counts as a normal completion.
        if (bus.mem_ready || wait_tc) begin
          state_d   = StIdle;
          mem_we_d  = 1'b0;
          timeout_d = timeout_q | ~bus.mem_ready;
          if (state_q == StIfBusy) begin
            if_valid_d = 1'b1;
            if_rdata_d = rdata_sel;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = rdata_sel;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_stall   = (bus.d_read | bus.d_write) & ~d_valid_q;
  assign bus.mem_en    = (state_q != StIdle);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: scenario tasks plus a scoreboard of
// expected read data and memory writes, checked as the DUT completes transactions.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   lat = 0;
  int   en_cnt = 0;
  logic force_rdy = 1'b0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [63:0] wr_q[$];

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C02_0004 : ((a ^ 32'hA5A5_0000) + 32'h1);
  endfunction

  // Memory model: ready after `lat` extra busy cycles, never when lat < 0.
  always @(posedge clk) en_cnt <= (!bus.mem_en || bus.mem_ready) ? 0 : en_cnt + 1;
  assign bus.mem_ready = force_rdy | (bus.mem_en && lat >= 0 && en_cnt == lat);
  assign bus.mem_rdata = mem_model(bus.mem_addr);

  // Scoreboard: every valid pulse and every completing write pops an expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [63:0] w;
    if (bus.if_valid) begin
      vectors++;
      if (if_q.size() == 0) begin
        miscompares++;
        $display("FAIL if_valid_unexpected: got if_valid=1 want no fetch outstanding (cyc %0d)", cyc);
      end else begin
        e = if_q.pop_front();
        if (bus.if_rdata !== e) begin
          miscompares++;
          $display("FAIL if_rdata: got %h want %h (cyc %0d)", bus.if_rdata, e, cyc);
        end
      end
    end
    if (bus.d_valid) begin
      vectors++;
      if (d_q.size() == 0) begin
        miscompares++;
        $display("FAIL d_valid_unexpected: got d_valid=1 want no data access outstanding (cyc %0d)", cyc);
      end else begin
        e = d_q.pop_front();
        if (bus.d_rdata !== e) begin
          miscompares++;
          $display("FAIL d_rdata: got %h want %h (cyc %0d)", bus.d_rdata, e, cyc);
        end
      end
    end
    if (bus.mem_en && bus.mem_we && bus.mem_ready) begin
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL mem_write_unexpected: got write to %h want none (cyc %0d)", bus.mem_addr, cyc);
      end else begin
        w = wr_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== w) begin
          miscompares++;
          $display("FAIL mem_write: got %h/%h want %h/%h", bus.mem_addr, bus.mem_wdata,
                   w[63:32], w[31:0]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit is_if, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((is_if && bus.if_valid) || (!is_if && bus.d_valid)) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({bus.if_valid, bus.d_valid, bus.mem_en, bus.mem_we, bus.timeout, bus.if_rdata,
         bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b we=%b to=%b addr=%h want all zero",
               bus.mem_en, bus.mem_we, bus.timeout, bus.mem_addr);
    end
    vectors++;
    if ({bus.if_stall, bus.d_stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_stalls: got %b want 00", {bus.if_stall, bus.d_stall});
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    int t0, at;
    lat = 0;
    next_cycle();
    t0 = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h40;
    if_q.push_back(32'h8C02_0004);
    @(negedge clk);
    vectors++;
    if (bus.mem_en !== 1'b0 || bus.if_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_cycle0: got en=%b stall=%b want en=0 stall=1", bus.mem_en, bus.if_stall);
    end
    @(negedge clk);
    vectors++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_cycle1: got en=%b addr=%h we=%b want 1/00000040/0",
               bus.mem_en, bus.mem_addr, bus.mem_we);
    end
    wait_valid(1'b1, 4, at);
    vectors++;
    if (at !== t0 + 2 || bus.d_valid !== 1'b0 || bus.if_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_latency: got cycle %0d d_valid=%b want cycle %0d d_valid=0",
               at - t0, bus.d_valid, 2);
    end
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.if_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_pulse: got valid=%b en=%b want 0/0", bus.if_valid, bus.mem_en);
    end
  endtask

  task automatic test_simultaneous();
    int t0, at;
    lat = 0;
    next_cycle();
    t0 = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h80;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h10;
    d_q.push_back(mem_model(32'h10));
    if_q.push_back(mem_model(32'h80));
    wait_valid(1'b0, 5, at);
    vectors++;
    if (at !== t0 + 2) begin
      miscompares++;
      $display("FAIL simul_d_latency: got cycle %0d want 2", at - t0);
    end
    next_cycle();
    bus.d_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h80) begin
      miscompares++;
      $display("FAIL simul_if_grant: got en=%b addr=%h want 1/00000080", bus.mem_en, bus.mem_addr);
    end
    wait_valid(1'b1, 5, at);
    vectors++;
    if (at !== t0 + 4) begin
      miscompares++;
      $display("FAIL simul_if_latency: got cycle %0d want 4", at - t0);
    end
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  // One tie in IDLE; the loser withdraws so only the winner completes.
  task automatic tie_round(input bit if_wins, input logic [31:0] ia, input logic [31:0] da,
                           input int n);
    int t0, at;
    next_cycle();
    t0 = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = ia;
    bus.d_read = 1'b1;
    bus.d_addr = da;
    if (if_wins) if_q.push_back(mem_model(ia));
    else d_q.push_back(mem_model(da));
    next_cycle();
    if (if_wins) bus.d_read = 1'b0;
    else bus.if_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.mem_addr !== (if_wins ? ia : da)) begin
      miscompares++;
      $display("FAIL starve_tie%0d: got addr %h want %h", n, bus.mem_addr, if_wins ? ia : da);
    end
    wait_valid(if_wins, 4, at);
    vectors++;
    if (at !== t0 + 2) begin
      miscompares++;
      $display("FAIL starve_tie%0d_latency: got cycle %0d want 2", n, at - t0);
    end
    next_cycle();
    bus.if_req = 1'b0;
    bus.d_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    lat = 0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    tie_round(1'b0, 32'h100, 32'h200, 1);
    tie_round(1'b0, 32'h104, 32'h204, 2);
    tie_round(1'b1, 32'h108, 32'h208, 3);
    tie_round(1'b0, 32'h10C, 32'h20C, 4);
  endtask

  task automatic test_idle_ready();
    next_cycle();
    force_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready_en: got %b want 0", bus.mem_en);
    end
    next_cycle();
    force_rdy = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.if_valid, bus.d_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_ready_valid: got %b want 00", {bus.if_valid, bus.d_valid});
    end
  endtask

  task automatic test_store_wait();
    int t0, at;
    lat = 0;
    next_cycle();
    t0 = cyc;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h20;
    d_q.push_back(mem_model(32'h20));
    wait_valid(1'b0, 5, at);
    vectors++;
    if (at !== t0 + 2) begin
      miscompares++;
      $display("FAIL load_latency: got cycle %0d want 2", at - t0);
    end
    next_cycle();
    bus.d_read = 1'b0;
    @(negedge clk);
    next_cycle();
    lat = 2;
    t0 = cyc;
    bus.d_write = 1'b1;
    bus.d_addr = 32'h08;
    bus.d_wdata = 32'hDEAD_BEEF;
    d_q.push_back(mem_model(32'h20));
    wr_q.push_back({32'h08, 32'hDEAD_BEEF});
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h08 ||
          bus.mem_wdata !== 32'hDEAD_BEEF || bus.d_stall !== 1'b1) begin
        miscompares++;
        $display("FAIL store_hold%0d: got en=%b we=%b addr=%h wdata=%h want 1/1/08/deadbeef",
                 i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
    end
    wait_valid(1'b0, 3, at);
    vectors++;
    if (at !== t0 + 4 || bus.mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL store_done: got cycle %0d we=%b want cycle 4 we=0", at - t0, bus.mem_we);
    end
    next_cycle();
    bus.d_write = 1'b0;
    lat = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int t0, at;
    next_cycle();
    vectors++;
    if (bus.timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pre: got %b want 0", bus.timeout);
    end
    lat = -1;
    t0 = cyc;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h30;
    d_q.push_back(32'h0);
    wait_valid(1'b0, 20, at);
    vectors++;
    if (at !== t0 + 16 || bus.timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_abort: got cycle %0d timeout=%b want cycle 16 timeout=1",
               at - t0, bus.timeout);
    end
    next_cycle();
    bus.d_read = 1'b0;
    lat = 0;
    @(negedge clk);
    vectors++;
    if (bus.mem_en !== 1'b0 || bus.timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got en=%b timeout=%b want 0/1", bus.mem_en, bus.timeout);
    end
    next_cycle();
    t0 = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h44;
    if_q.push_back(mem_model(32'h44));
    wait_valid(1'b1, 5, at);
    vectors++;
    if (at !== t0 + 2 || bus.timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_recover: got cycle %0d timeout=%b want cycle 2 timeout=1",
               at - t0, bus.timeout);
    end
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t0, at;
    lat = -1;
    next_cycle();
    t0 = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h50;
    if_q.push_back(mem_model(32'h50));
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_busy: got en=%b want 1", bus.mem_en);
    end
    next_cycle();
    rst = 1'b0;
    lat = 0;
    @(negedge clk);
    vectors++;
    if ({bus.if_valid, bus.d_valid, bus.mem_en, bus.mem_we, bus.timeout, bus.if_rdata,
         bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got en=%b valid=%b to=%b addr=%h want all zero",
               bus.mem_en, bus.if_valid, bus.timeout, bus.mem_addr);
    end
    @(negedge clk);
    vectors++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h50) begin
      miscompares++;
      $display("FAIL rstmid_regrant: got en=%b addr=%h want 1/00000050", bus.mem_en, bus.mem_addr);
    end
    wait_valid(1'b1, 4, at);
    vectors++;
    if (at !== t0 + 5) begin
      miscompares++;
      $display("FAIL rstmid_latency: got cycle %0d want 5", at - t0);
    end
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_idle_ready();
    test_store_wait();
    test_timeout();
    test_reset_mid();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (if_q.size() != 0 || d_q.size() != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d outstanding want 0/0/0",
               if_q.size(), d_q.size(), wr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
